int_sequencer: RTL and testbench
================================

INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 Parameter: none; the vector reset values are fixed at A = 16'hFDA9 and B = 16'hFB53.
REQ-002 clk  input  1  single system clock; all state updates on posedge.
REQ-003 n_rst  input  1  reset, asynchronous assert, active-low.
REQ-004 i_inta, i_intb  input  1 each  raw interrupt request levels.
REQ-005 i_cfg_we  input  1  config write strobe; i_cfg_data[2:0] = {priority, en_b, en_a}.
REQ-006 i_cfg_data  input  3  config payload.
REQ-007 i_vec_we  input  2  bit0 writes vector A, bit1 writes vector B, from i_data_bus.
REQ-008 i_data_bus  input  16  vector write data.
REQ-009 i_instr_done  input  1  high for one cycle at an instruction boundary.
REQ-010 i_pc  input  16  current program counter (return address).
REQ-011 o_save_req / i_save_ack  output/input  1 each  return-address push handshake.
REQ-012 o_save_data  output  16  latched return address.
REQ-013 i_iret  input  1  return-from-interrupt pulse.
REQ-014 o_addr_bus, o_addr_valid, o_pc_set  output  16/1/1  vector address and PC load strobe.
REQ-015 o_decoder_interrupt, o_busy  output  1 each  status; o_active_src  output  2  01 = A, 10 = B, 00 = none.

Function
REQ-016 Edge detect: a pending bit sets at the posedge where the input is 1, the previous registered sample is 0, and the source is enabled; edges on a disabled source are discarded.
REQ-017 Writing en_x = 0 clears pend_x in the same cycle.
REQ-018 FSM states are IDLE, SAVE, VECTOR, SERVICE.
REQ-019 IDLE -> SAVE when (pend_a | pend_b) & i_instr_done; at that transition the block latches ret_pc <= i_pc, win <= arbitrated source, and vec <= the winner's vector.
REQ-020 Arbitration: only one source pending -> that source wins; both pending -> A wins if priority = 0, B wins if priority = 1.
REQ-021 SAVE: o_save_req = 1 and o_save_data = ret_pc are held stable until i_save_ack is sampled high, then the FSM goes to VECTOR.
REQ-022 VECTOR lasts exactly 1 cycle: o_addr_valid = 1, o_pc_set = 1, o_addr_bus = vec, the winner's pending bit clears, then the FSM goes to SERVICE.
REQ-023 A new edge on the winner in the VECTOR cycle wins over the clear, so pending stays 1.
REQ-024 SERVICE: o_active_src = win; on i_iret the FSM goes to IDLE and o_active_src becomes 00. There is no nesting; edges that arrive during SAVE, VECTOR or SERVICE latch as pending.
REQ-025 Latency: from the i_instr_done cycle, o_save_req is high on the next cycle; o_pc_set is high 1 cycle after the ack cycle.
REQ-026 o_addr_bus = 0 whenever o_addr_valid = 0; this block never tristates.
REQ-027 o_decoder_interrupt = 1 in SAVE and VECTOR; o_busy = 1 in any state other than IDLE.
REQ-028 Config and vector writes are accepted in all states and take effect the next cycle; an interrupt already in flight keeps its latched vec.
REQ-029 i_iret outside SERVICE is ignored; i_save_ack outside SAVE is ignored.

Reset
REQ-030 On n_rst low: FSM = IDLE, pending = 0, edge samples = 0, en_a = en_b = 1, priority = 0, vectors = FDA9/FB53, ret_pc = 0, and all outputs = 0.
REQ-031 Reset asserted in any state aborts the operation; no pc_set pulse is emitted.

Configuration
REQ-032 Macro INT_SAVE_TIMEOUT_EN, when defined: a 4-bit counter runs in SAVE; if there is no ack after 15 cycles in SAVE, the FSM returns to IDLE, pending is kept, and the sticky output o_fault (1 bit) sets; o_fault is cleared by a config write.
REQ-033 When INT_SAVE_TIMEOUT_EN is undefined: SAVE waits indefinitely and o_fault is tied to 0.

Verification
REQ-034 Single edge: i_inta rises, then i_instr_done with i_pc = 16'h0123 -> save_data = 0123; after the ack, o_pc_set with addr = FDA9, o_active_src = 01.
REQ-035 Simultaneous edges with priority = 1 -> B serviced first (addr FB53); after i_iret, A is serviced next (FDA9).
REQ-036 Vector write 16'h4000 to A, then an A edge -> addr = 4000; a vector write during SAVE -> still 4000.
REQ-037 en_a = 0, then an A edge -> no pending and no o_save_req; a B edge is still serviced.
REQ-038 n_rst pulsed while in SAVE -> all outputs 0, defaults restored, and a later A edge yields FDA9.
REQ-039 With INT_SAVE_TIMEOUT_EN defined: ack withheld for 15 cycles -> IDLE, o_fault = 1, pending retained.

Source files
------------

// File: rtl/int_sequencer_if.sv
// Signal bundle between the interrupt sequencer and its CPU core: request lines, config/vector writes,
// return-address push handshake and vector load; slave = sequencer side, master = core/bench side.
interface int_sequencer_if;
  logic        i_inta;
  logic        i_intb;
  logic        i_cfg_we;
  logic [2:0]  i_cfg_data;
  logic [1:0]  i_vec_we;
  logic [15:0] i_data_bus;
  logic        i_instr_done;
  logic [15:0] i_pc;
  logic        o_save_req;
  logic        i_save_ack;
  logic [15:0] o_save_data;
  logic        i_iret;
  logic [15:0] o_addr_bus;
  logic        o_addr_valid;
  logic        o_pc_set;
  logic        o_decoder_interrupt;
  logic        o_busy;
  logic [1:0]  o_active_src;
  logic        o_fault;

  modport slave (
    input  i_inta, i_intb, i_cfg_we, i_cfg_data, i_vec_we, i_data_bus,
           i_instr_done, i_pc, i_save_ack, i_iret,
    output o_save_req, o_save_data, o_addr_bus, o_addr_valid, o_pc_set,
           o_decoder_interrupt, o_busy, o_active_src, o_fault
  );

  modport master (
    output i_inta, i_intb, i_cfg_we, i_cfg_data, i_vec_we, i_data_bus,
           i_instr_done, i_pc, i_save_ack, i_iret,
    input  o_save_req, o_save_data, o_addr_bus, o_addr_valid, o_pc_set,
           o_decoder_interrupt, o_busy, o_active_src, o_fault
  );
endinterface

// File: rtl/int_sequencer.sv
// Two-source edge-triggered interrupt sequencer: save_req 1 cycle after instr_done, pc_set 1 cycle after ack;
// SAVE stalls until i_save_ack (optional INT_SAVE_TIMEOUT_EN aborts after 15 cycles and sets sticky o_fault).
module int_sequencer (
  input  logic            clk,
  input  logic            n_rst,
  int_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SAVE, VECTOR, SERVICE} state_t;

  localparam logic [15:0] VEC_A_RST = 16'hFDA9;
  localparam logic [15:0] VEC_B_RST = 16'hFB53;
  localparam logic [1:0]  SRC_A     = 2'b01;
  localparam logic [1:0]  SRC_B     = 2'b10;

  state_t      state, state_n;
  logic        inta_q, intb_q;
  logic        pend_a, pend_b;
  logic        en_a, en_b, prio;
  logic [15:0] vec_a, vec_b, vec, ret_pc;
  logic [1:0]  win, win_n;
  logic        take, rise_a, rise_b, clr_a, clr_b, timeout;

  // outputs are pure decodes of state plus latched transaction data
  logic        save_req, addr_valid, pc_set, dec_int;
  logic [15:0] save_data, addr_bus;
  logic [1:0]  active_src;

  assign rise_a = bus.i_inta & ~inta_q & en_a;
  assign rise_b = bus.i_intb & ~intb_q & en_b;
  assign win_n  = (pend_b & (~pend_a | prio)) ? SRC_B : SRC_A;
  assign clr_a  = (state == VECTOR) && (win == SRC_A);
  assign clr_b  = (state == VECTOR) && (win == SRC_B);

`ifdef INT_SAVE_TIMEOUT_EN
  logic [3:0] save_cnt;
  logic       fault;

  assign timeout = (state == SAVE) && !bus.i_save_ack && (save_cnt == 4'd14);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      save_cnt <= 4'd0;
      fault    <= 1'b0;
    end else begin
      save_cnt <= (state == SAVE) ? save_cnt + 4'd1 : 4'd0;
      if (timeout)
        fault <= 1'b1;
      else if (bus.i_cfg_we)
        fault <= 1'b0;
    end
  end

  assign bus.o_fault = fault;
`else
  assign timeout     = 1'b0;
  assign bus.o_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    take       = 1'b0;
    save_req   = 1'b0;
    save_data  = 16'h0000;
    addr_valid = 1'b0;
    pc_set     = 1'b0;
    addr_bus   = 16'h0000;
    dec_int    = 1'b0;
    active_src = 2'b00;
    case (state)
      IDLE: begin
        if ((pend_a | pend_b) & bus.i_instr_done) begin
          state_n = SAVE;
          take    = 1'b1;
        end
      end
      SAVE: begin
        save_req  = 1'b1;
        save_data = ret_pc;
        dec_int   = 1'b1;
        if (bus.i_save_ack)
          state_n = VECTOR;
        else if (timeout)
          state_n = IDLE;
      end
      VECTOR: begin
        addr_valid = 1'b1;
        pc_set     = 1'b1;
        addr_bus   = vec;
        dec_int    = 1'b1;
        state_n    = SERVICE;
      end
      SERVICE: begin
        active_src = win;
        if (bus.i_iret)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inta_q <= 1'b0;
      intb_q <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      en_a   <= 1'b1;
      en_b   <= 1'b1;
      prio   <= 1'b0;
      vec_a  <= VEC_A_RST;
      vec_b  <= VEC_B_RST;
      vec    <= 16'h0000;
      ret_pc <= 16'h0000;
      win    <= 2'b00;
    end else begin
      inta_q <= bus.i_inta;
      intb_q <= bus.i_intb;
      // a fresh edge beats the vector-cycle clear; disabling a source beats both
      pend_a <= ((pend_a & ~clr_a) | rise_a) & ~(bus.i_cfg_we & ~bus.i_cfg_data[0]);
      pend_b <= ((pend_b & ~clr_b) | rise_b) & ~(bus.i_cfg_we & ~bus.i_cfg_data[1]);
      if (bus.i_cfg_we)
        {prio, en_b, en_a} <= bus.i_cfg_data;
      if (bus.i_vec_we[0])
        vec_a <= bus.i_data_bus;
      if (bus.i_vec_we[1])
        vec_b <= bus.i_data_bus;
      if (take) begin
        ret_pc <= bus.i_pc;
        win    <= win_n;
        vec    <= (win_n == SRC_A) ? vec_a : vec_b;
      end
    end
  end

  assign bus.o_save_req          = save_req;
  assign bus.o_save_data         = save_data;
  assign bus.o_addr_valid        = addr_valid;
  assign bus.o_pc_set            = pc_set;
  assign bus.o_addr_bus          = addr_bus;
  assign bus.o_decoder_interrupt = dec_int;
  assign bus.o_busy              = (state != IDLE);
  assign bus.o_active_src        = active_src;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed plus randomized bench for int_sequencer against a transaction-level model of pending/priority/vectors.
module tb_int_sequencer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int_sequencer_if bus ();

  int_sequencer dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // reference model state
  bit          m_pa, m_pb, m_qa, m_qb, m_ena, m_enb, m_pri;
  bit          m_clr_a, m_clr_b;
  logic [15:0] m_va, m_vb;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pa = 0; m_pb = 0; m_qa = 0; m_qb = 0;
    m_ena = 1; m_enb = 1; m_pri = 0;
    m_clr_a = 0; m_clr_b = 0;
    m_va = 16'hFDA9; m_vb = 16'hFB53;
  endtask

  // advance one clock, folding the currently driven inputs into the model
  task automatic tick();
    bit ra, rb;
    ra = bus.i_inta && !m_qa && m_ena;
    rb = bus.i_intb && !m_qb && m_enb;
    if (m_clr_a) m_pa = 0;
    if (m_clr_b) m_pb = 0;
    if (ra) m_pa = 1;
    if (rb) m_pb = 1;
    if (bus.i_cfg_we) begin
      if (!bus.i_cfg_data[0]) m_pa = 0;
      if (!bus.i_cfg_data[1]) m_pb = 0;
      m_ena = bus.i_cfg_data[0];
      m_enb = bus.i_cfg_data[1];
      m_pri = bus.i_cfg_data[2];
    end
    if (bus.i_vec_we[0]) m_va = bus.i_data_bus;
    if (bus.i_vec_we[1]) m_vb = bus.i_data_bus;
    m_qa = bus.i_inta;
    m_qb = bus.i_intb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_save_req"}, 16'(bus.o_save_req), 16'h0);
    chk({tag, "_save_data"}, bus.o_save_data, 16'h0);
    chk({tag, "_addr_bus"}, bus.o_addr_bus, 16'h0);
    chk({tag, "_addr_valid"}, 16'(bus.o_addr_valid), 16'h0);
    chk({tag, "_pc_set"}, 16'(bus.o_pc_set), 16'h0);
    chk({tag, "_dec_int"}, 16'(bus.o_decoder_interrupt), 16'h0);
    chk({tag, "_busy"}, 16'(bus.o_busy), 16'h0);
    chk({tag, "_active_src"}, 16'(bus.o_active_src), 16'h0);
  endtask

  task automatic do_reset();
    bus.i_inta = 0; bus.i_intb = 0; bus.i_cfg_we = 0; bus.i_cfg_data = 3'b000;
    bus.i_vec_we = 2'b00; bus.i_data_bus = 16'h0; bus.i_instr_done = 0;
    bus.i_pc = 16'h0; bus.i_save_ack = 0; bus.i_iret = 0;
    n_rst = 0;
    model_reset();
    #1;
    check_idle_outputs("rst");
    chk("rst_fault", 16'(bus.o_fault), 16'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_pc_set", 16'(bus.o_pc_set), 16'h0);
    n_rst = 1;
    tick();
  endtask

  task automatic pulse(input bit a, input bit b);
    bus.i_inta = a; bus.i_intb = b;
    tick();
    bus.i_inta = 0; bus.i_intb = 0;
    tick();
  endtask

  task automatic cfg(input logic [2:0] d);
    bus.i_cfg_we = 1; bus.i_cfg_data = d;
    tick();
    bus.i_cfg_we = 0;
  endtask

  task automatic vec_write(input logic [1:0] we, input logic [15:0] d);
    bus.i_vec_we = we; bus.i_data_bus = d;
    tick();
    bus.i_vec_we = 2'b00;
  endtask

  // one full boundary: instr_done, save handshake, vector cycle, service, iret
  task automatic serve(input logic [15:0] pc, input int hold, input bit wr_vec);
    logic [1:0]  w;
    logic [15:0] v;
    bit          any;
    any = m_pa || m_pb;
    if (m_pa && m_pb) w = m_pri ? 2'b10 : 2'b01;
    else if (m_pa)    w = 2'b01;
    else              w = 2'b10;
    v = (w == 2'b01) ? m_va : m_vb;
    bus.i_pc = pc; bus.i_instr_done = 1;
    tick();
    bus.i_instr_done = 0; bus.i_pc = 16'($urandom);
    chk("save_req_start", 16'(bus.o_save_req), 16'(any));
    chk("busy_start", 16'(bus.o_busy), 16'(any));
    if (!any) return;
    chk("save_data", bus.o_save_data, pc);
    chk("dec_int_save", 16'(bus.o_decoder_interrupt), 16'h1);
    for (int i = 0; i < hold; i++) begin
      bus.i_inta = 1'($urandom); bus.i_intb = 1'($urandom);
      bus.i_iret = 1'($urandom);
      if (wr_vec) begin
        bus.i_vec_we = 2'($urandom); bus.i_data_bus = 16'($urandom);
      end
      tick();
      bus.i_vec_we = 2'b00; bus.i_iret = 0;
      chk("save_req_hold", 16'(bus.o_save_req), 16'h1);
      chk("save_data_hold", bus.o_save_data, pc);
      chk("pc_set_hold", 16'(bus.o_pc_set), 16'h0);
    end
    bus.i_save_ack = 1;
    tick();
    bus.i_save_ack = 0;
    chk("pc_set", 16'(bus.o_pc_set), 16'h1);
    chk("addr_valid", 16'(bus.o_addr_valid), 16'h1);
    chk("addr_bus", bus.o_addr_bus, v);
    chk("save_req_vec", 16'(bus.o_save_req), 16'h0);
    m_clr_a = (w == 2'b01); m_clr_b = (w == 2'b10);
    bus.i_inta = 1'($urandom); bus.i_intb = 1'($urandom);
    tick();
    m_clr_a = 0; m_clr_b = 0;
    chk("active_src", 16'(bus.o_active_src), 16'(w));
    chk("addr_bus_svc", bus.o_addr_bus, 16'h0);
    chk("pc_set_svc", 16'(bus.o_pc_set), 16'h0);
    chk("dec_int_svc", 16'(bus.o_decoder_interrupt), 16'h0);
    bus.i_save_ack = 1;
    tick();
    bus.i_save_ack = 0;
    chk("ack_ignored_svc", 16'(bus.o_active_src), 16'(w));
    bus.i_iret = 1;
    tick();
    bus.i_iret = 0;
    chk("active_src_iret", 16'(bus.o_active_src), 16'h0);
    chk("busy_iret", 16'(bus.o_busy), 16'h0);
    bus.i_inta = 0; bus.i_intb = 0;
    tick();
  endtask

  initial begin
    do_reset();

    // single A edge with default vectors
    pulse(1, 0);
    serve(16'h0123, 2, 0);

    // simultaneous edges, B has priority, then A follows
    cfg(3'b111);
    pulse(1, 1);
    chk("both_pending_b_first", 16'(m_pri ? m_vb : m_va), 16'hFB53);
    serve(16'h1000, 1, 0);
    serve(16'h1004, 0, 0);

    // reprogrammed A vector, with writes during SAVE not disturbing it
    cfg(3'b011);
    vec_write(2'b01, 16'h4000);
    pulse(1, 0);
    serve(16'h2222, 3, 1);

    // disabled A discards edges, B still served
    cfg(3'b010);
    pulse(1, 0);
    serve(16'h3333, 0, 0);
    pulse(0, 1);
    serve(16'h3334, 1, 0);
    cfg(3'b011);

    // reset asserted mid-SAVE aborts and restores defaults
    pulse(1, 0);
    bus.i_instr_done = 1; bus.i_pc = 16'h5555;
    tick();
    bus.i_instr_done = 0;
    chk("pre_reset_save_req", 16'(bus.o_save_req), 16'h1);
    do_reset();
    pulse(1, 0);
    serve(16'h6666, 1, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) cfg(3'($urandom_range(7)));
      if ($urandom_range(3) == 0) vec_write(2'($urandom_range(3)), 16'($urandom));
      pulse(1'($urandom), 1'($urandom));
      serve(16'($urandom), $urandom_range(5), 1'($urandom));
`ifndef INT_SAVE_TIMEOUT_EN
      chk("fault_tied_low", 16'(bus.o_fault), 16'h0);
`endif
    end

`ifdef INT_SAVE_TIMEOUT_EN
    cfg(3'b011);
    pulse(1, 0);
    bus.i_instr_done = 1; bus.i_pc = 16'h7777;
    tick();
    bus.i_instr_done = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("timeout_still_save", 16'(bus.o_save_req), 16'h1);
    end
    tick();
    chk("timeout_idle", 16'(bus.o_busy), 16'h0);
    chk("timeout_fault", 16'(bus.o_fault), 16'h1);
    serve(16'h7778, 0, 0);
    chk("fault_sticky", 16'(bus.o_fault), 16'h1);
    cfg(3'b011);
    chk("fault_cleared", 16'(bus.o_fault), 16'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
